shb_arbiter2: RTL and testbench

Two-master arbiter for the shrinked 8-bit AHB. It shares the single system bus between the CPU (master 0) and the cDMA engine (master 1), and drives the existing slave decode (fsb8 / on-chip functions) as if it were one master. It tracks address-phase and data-phase ownership separately, so handovers are pipelined with no dead cycle. Arbitration is round-robin with burst locking and a bounded hold counter.

---
 rtl/shb_arbiter2_if.sv | 53 +++++
 rtl/shb_arbiter2.sv | 80 ++++++++
 tb/tb_shb_arbiter2.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shb_arbiter2_if.sv
// Bus bundle between the two masters, the arbiter and the slave decode.
// The master modport is the arbiter's view: it masters the slave-side bus and
// answers the two requesting masters. The slave modport is the opposite view.
interface shb_arbiter2_if #(
    parameter int unsigned ADDR_WID = 32
);
    logic [ADDR_WID-1:0] m0_haddr;
    logic [ADDR_WID-1:0] m1_haddr;
    logic                m0_hwrite;
    logic                m1_hwrite;
    logic                m0_hburst;
    logic                m1_hburst;
    logic                m0_htrans;
    logic                m1_htrans;
    logic [7:0]          m0_hwdata;
    logic [7:0]          m1_hwdata;
    logic                m0_hready;
    logic                m1_hready;
    logic                m0_hresp;
    logic                m1_hresp;
    logic [7:0]          m0_hrdata;
    logic [7:0]          m1_hrdata;

    logic [ADDR_WID-1:0] s_haddr;
    logic                s_hwrite;
    logic                s_hburst;
    logic                s_htrans;
    logic [7:0]          s_hwdata;
    logic                s_hready;
    logic                s_hresp;
    logic [7:0]          s_hrdata;

    logic                owner;
    logic                dvalid;

    modport master (
        input  m0_haddr, m1_haddr, m0_hwrite, m1_hwrite, m0_hburst, m1_hburst,
        input  m0_htrans, m1_htrans, m0_hwdata, m1_hwdata,
        output m0_hready, m1_hready, m0_hresp, m1_hresp, m0_hrdata, m1_hrdata,
        output s_haddr, s_hwrite, s_hburst, s_htrans, s_hwdata,
        input  s_hready, s_hresp, s_hrdata,
        output owner, dvalid
    );

    modport slave (
        output m0_haddr, m1_haddr, m0_hwrite, m1_hwrite, m0_hburst, m1_hburst,
        output m0_htrans, m1_htrans, m0_hwdata, m1_hwdata,
        input  m0_hready, m1_hready, m0_hresp, m1_hresp, m0_hrdata, m1_hrdata,
        input  s_haddr, s_hwrite, s_hburst, s_htrans, s_hwdata,
        output s_hready, s_hresp, s_hrdata,
        input  owner, dvalid
    );
endinterface

// File: rtl/shb_arbiter2.sv
// Two-master round-robin arbiter for the 8-bit SHB. Address-phase and
// data-phase ownership are tracked separately so a handover overlaps the old
// owner's data phase with the new owner's address phase.
module shb_arbiter2 #(
    parameter int unsigned ADDR_WID = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           hclk,
    input  logic           hreset_n,
    shb_arbiter2_if.master bus
);
    // Last beat index a locked burst may take while the other master waits.
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic                r_owner;
    logic                r_downer;
    logic                r_dvalid;
    logic [7:0]          r_cnt;

    logic                w_own_req;
    logic                w_own_burst;
    logic                w_oth_req;
    logic                w_switch;
    logic                w_d0;
    logic                w_d1;
    logic [ADDR_WID-1:0] w_own_addr;

    // Request decode relative to the current address-phase owner.
    always_comb begin
        w_own_req   = r_owner ? bus.m1_htrans : bus.m0_htrans;
        w_own_burst = r_owner ? bus.m1_hburst : bus.m0_hburst;
        w_oth_req   = r_owner ? bus.m0_htrans : bus.m1_htrans;
        w_own_addr  = r_owner ? bus.m1_haddr  : bus.m0_haddr;
        w_switch    = w_oth_req & (~w_own_req | ~w_own_burst | (r_cnt == HoldLast));
        w_d0        = r_dvalid & ~r_downer;
        w_d1        = r_dvalid & r_downer;
    end

    // Ownership state only advances on accepted cycles; wait states freeze it.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_owner  <= 1'b0;
            r_downer <= 1'b0;
            r_dvalid <= 1'b0;
            r_cnt    <= 8'd0;
        end else if (bus.s_hready) begin
            r_dvalid <= w_own_req;
            r_downer <= r_owner;
            if (w_switch) begin
                r_owner <= ~r_owner;
                r_cnt   <= 8'd0;
            end else if (w_own_req && w_own_burst) begin
                // Uncontested bursts run on; the counter parks at the last index.
                r_cnt <= (r_cnt == HoldLast) ? r_cnt : r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    // Address/write muxes to the slave and per-master response steering.
    always_comb begin
        bus.s_haddr   = w_own_addr;
        bus.s_hwrite  = r_owner ? bus.m1_hwrite : bus.m0_hwrite;
        bus.s_hburst  = w_own_burst;
        bus.s_htrans  = w_own_req;
        bus.s_hwdata  = r_downer ? bus.m1_hwdata : bus.m0_hwdata;

        // A waiting non-owner sees hready low and holds its address.
        bus.m0_hready = bus.s_hready & (~r_owner | w_d0);
        bus.m1_hready = bus.s_hready & (r_owner | w_d1);
        bus.m0_hresp  = w_d0 & bus.s_hresp;
        bus.m1_hresp  = w_d1 & bus.s_hresp;
        bus.m0_hrdata = w_d0 ? bus.s_hrdata : 8'h00;
        bus.m1_hrdata = w_d1 ? bus.s_hrdata : 8'h00;

        bus.owner     = r_owner;
        bus.dvalid    = r_dvalid;
    end
endmodule

// File: tb/tb_shb_arbiter2.sv
// Directed self-checking bench for shb_arbiter2 (MAX_HOLD = 4).
module tb_shb_arbiter2;
    logic hclk;
    logic hreset_n;
    int   n_checks;
    int   n_errors;

    shb_arbiter2_if #(.ADDR_WID(32)) bus ();

    shb_arbiter2 #(
        .ADDR_WID(32),
        .MAX_HOLD(4)
    ) dut (
        .hclk    (hclk),
        .hreset_n(hreset_n),
        .bus     (bus)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic idle_masters();
        bus.m0_haddr  = '0; bus.m1_haddr  = '0;
        bus.m0_hwrite = 0;  bus.m1_hwrite = 0;
        bus.m0_hburst = 0;  bus.m1_hburst = 0;
        bus.m0_htrans = 0;  bus.m1_htrans = 0;
        bus.m0_hwdata = 0;  bus.m1_hwdata = 0;
        bus.s_hready  = 1;  bus.s_hresp   = 0;  bus.s_hrdata = 8'h00;
    endtask

    // Called 1 time unit after a posedge; leaves time at posedge+1.
    task automatic do_reset();
        idle_masters();
        hreset_n = 1'b0;
        #2;
        hreset_n = 1'b1;
        @(posedge hclk); #1;
    endtask

    task automatic next_cycle();
        @(posedge hclk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        // m1 takes the bus and starts a burst.
        bus.m1_htrans = 1; bus.m1_hburst = 1; bus.m1_haddr = 32'h300;
        next_cycle();
        next_cycle();
        n_checks++;
        if (bus.owner !== 1'b1 || bus.dvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_own got owner=%0b dvalid=%0b want 1 1", bus.owner, bus.dvalid);
        end
        bus.m0_htrans = 1; bus.m0_haddr = 32'hABC;
        hreset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.owner !== 1'b0) begin
            n_errors++; $display("FAIL reset_owner got %0b want 0", bus.owner);
        end
        n_checks++;
        if (bus.dvalid !== 1'b0) begin
            n_errors++; $display("FAIL reset_dvalid got %0b want 0", bus.dvalid);
        end
        n_checks++;
        if (bus.m1_hready !== 1'b0) begin
            n_errors++; $display("FAIL reset_m1_hready got %0b want 0", bus.m1_hready);
        end
        n_checks++;
        if (bus.s_htrans !== 1'b1 || bus.s_haddr !== 32'hABC) begin
            n_errors++;
            $display("FAIL reset_follow_m0 got htrans=%0b addr=%h want 1 00000abc",
                     bus.s_htrans, bus.s_haddr);
        end
        #1;
        hreset_n = 1'b1;
        // Parked master gets its address out with no extra latency.
        @(negedge hclk);
        n_checks++;
        if (bus.m0_hready !== 1'b1 || bus.s_haddr !== 32'hABC) begin
            n_errors++;
            $display("FAIL parked_m0 got hready=%0b addr=%h want 1 00000abc",
                     bus.m0_hready, bus.s_haddr);
        end
        next_cycle();
        // m0 single accepted, m1 still requesting -> handover.
        n_checks++;
        if (bus.owner !== 1'b1) begin
            n_errors++; $display("FAIL reset_then_switch got owner=%0b want 1", bus.owner);
        end
        do_reset();
    endtask

    task automatic test_idle_handover();
        do_reset();
        bus.m1_htrans = 1; bus.m1_haddr = 32'h00C0_0500; bus.m1_hwrite = 0;
        @(negedge hclk);
        n_checks++;
        if (bus.m1_hready !== 1'b0 || bus.owner !== 1'b0) begin
            n_errors++;
            $display("FAIL grant_wait got hready=%0b owner=%0b want 0 0", bus.m1_hready, bus.owner);
        end
        next_cycle();
        @(negedge hclk);
        n_checks++;
        if (bus.owner !== 1'b1 || bus.s_haddr !== 32'h00C0_0500 || bus.s_htrans !== 1'b1) begin
            n_errors++;
            $display("FAIL grant_addr got owner=%0b addr=%h htrans=%0b want 1 00c00500 1",
                     bus.owner, bus.s_haddr, bus.s_htrans);
        end
        n_checks++;
        if (bus.m1_hready !== 1'b1) begin
            n_errors++; $display("FAIL grant_hready got %0b want 1", bus.m1_hready);
        end
        next_cycle();
        bus.m1_htrans = 0; bus.s_hrdata = 8'hA5;
        @(negedge hclk);
        n_checks++;
        if (bus.dvalid !== 1'b1 || bus.m1_hrdata !== 8'hA5) begin
            n_errors++;
            $display("FAIL grant_rdata got dvalid=%0b rdata=%h want 1 a5", bus.dvalid, bus.m1_hrdata);
        end
        n_checks++;
        if (bus.m0_hrdata !== 8'h00) begin
            n_errors++; $display("FAIL grant_m0_rdata got %h want 00", bus.m0_hrdata);
        end
        next_cycle();
        bus.s_hrdata = 8'h00;
        @(negedge hclk);
        n_checks++;
        if (bus.owner !== 1'b1 || bus.dvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL park_last got owner=%0b dvalid=%0b want 1 0", bus.owner, bus.dvalid);
        end
        next_cycle();
    endtask

    // Starts with the bus parked on m1 from the previous test.
    task automatic test_simultaneous();
        logic       exp_owner;
        logic [7:0] exp_data;
        bus.m0_htrans = 1; bus.m0_hwrite = 1; bus.m0_hwdata = 8'h11; bus.m0_haddr = 32'h10;
        bus.m1_htrans = 1; bus.m1_hwrite = 1; bus.m1_hwdata = 8'h22; bus.m1_haddr = 32'h20;
        for (int i = 0; i < 5; i++) begin
            exp_owner = (i % 2 == 0) ? 1'b1 : 1'b0;
            exp_data  = (i % 2 == 1) ? 8'h22 : 8'h11;
            @(negedge hclk);
            n_checks++;
            if (bus.owner !== exp_owner) begin
                n_errors++; $display("FAIL alt_owner[%0d] got %0b want %0b", i, bus.owner, exp_owner);
            end
            if (i > 0) begin
                n_checks++;
                if (bus.dvalid !== 1'b1 || bus.s_hwdata !== exp_data) begin
                    n_errors++;
                    $display("FAIL alt_wdata[%0d] got dvalid=%0b data=%h want 1 %h",
                             i, bus.dvalid, bus.s_hwdata, exp_data);
                end
            end
            next_cycle();
        end
        idle_masters();
        next_cycle();
    endtask

    task automatic test_burst_lock();
        int          m0_rem;
        int          m1_rem;
        int          nbeats;
        logic [31:0] got [16];
        logic [31:0] exp_addr;
        do_reset();
        m0_rem = 10;
        m1_rem = 1;
        nbeats = 0;
        for (int cyc = 0; cyc < 40 && (m0_rem > 0 || m1_rem > 0); cyc++) begin
            bus.m0_htrans = (m0_rem > 0); bus.m0_hburst = 1;
            bus.m0_haddr  = 32'h100 + 32'(10 - m0_rem);
            bus.m1_htrans = (m1_rem > 0); bus.m1_hburst = 0;
            bus.m1_haddr  = 32'h200;
            @(negedge hclk);
            if (bus.s_htrans && nbeats < 16) begin
                got[nbeats] = bus.s_haddr;
                nbeats++;
                if (bus.owner == 1'b0) m0_rem--;
                else m1_rem--;
            end
            next_cycle();
        end
        idle_masters();
        n_checks++;
        if (nbeats !== 11) begin
            n_errors++; $display("FAIL burst_beats got %0d want 11", nbeats);
        end
        for (int i = 0; i < 11 && i < nbeats; i++) begin
            if (i < 4) exp_addr = 32'h100 + 32'(i);
            else if (i == 4) exp_addr = 32'h200;
            else exp_addr = 32'h100 + 32'(i - 1);
            n_checks++;
            if (got[i] !== exp_addr) begin
                n_errors++; $display("FAIL burst_addr[%0d] got %h want %h", i, got[i], exp_addr);
            end
        end
        next_cycle();
    endtask

    task automatic test_wait_states();
        do_reset();
        bus.m0_htrans = 1; bus.m0_haddr = 32'h40;
        bus.m1_htrans = 1; bus.m1_haddr = 32'h80;
        next_cycle();
        // Handover cycle: m1 address phase over m0 data phase, slave stalls.
        bus.m0_htrans = 0;
        bus.s_hready  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            n_checks++;
            if (bus.owner !== 1'b1 || bus.s_haddr !== 32'h80 || bus.dvalid !== 1'b1) begin
                n_errors++;
                $display("FAIL wait_frozen[%0d] got owner=%0b addr=%h dvalid=%0b want 1 00000080 1",
                         i, bus.owner, bus.s_haddr, bus.dvalid);
            end
            n_checks++;
            if (bus.m0_hready !== 1'b0 || bus.m1_hready !== 1'b0) begin
                n_errors++;
                $display("FAIL wait_hready[%0d] got m0=%0b m1=%0b want 0 0",
                         i, bus.m0_hready, bus.m1_hready);
            end
            next_cycle();
        end
        bus.s_hready = 1;
        @(negedge hclk);
        n_checks++;
        if (bus.m0_hready !== 1'b1 || bus.m1_hready !== 1'b1) begin
            n_errors++;
            $display("FAIL handover_both got m0=%0b m1=%0b want 1 1", bus.m0_hready, bus.m1_hready);
        end
        next_cycle();
        bus.m1_htrans = 0;
    endtask

    // Continues from the wait-state test: m1 is now in its data phase.
    task automatic test_error();
        bus.s_hresp  = 1;
        bus.s_hrdata = 8'h5A;
        @(negedge hclk);
        n_checks++;
        if (bus.m1_hresp !== 1'b1 || bus.m0_hresp !== 1'b0) begin
            n_errors++;
            $display("FAIL err_route got m1=%0b m0=%0b want 1 0", bus.m1_hresp, bus.m0_hresp);
        end
        n_checks++;
        if (bus.m1_hrdata !== 8'h5A || bus.m0_hrdata !== 8'h00) begin
            n_errors++;
            $display("FAIL err_rdata got m1=%h m0=%h want 5a 00", bus.m1_hrdata, bus.m0_hrdata);
        end
        next_cycle();
        bus.s_hresp  = 0;
        bus.s_hrdata = 8'h00;
        @(negedge hclk);
        n_checks++;
        if (bus.owner !== 1'b1 || bus.dvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL err_no_arb got owner=%0b dvalid=%0b want 1 0", bus.owner, bus.dvalid);
        end
        next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        hreset_n = 1'b0;
        idle_masters();
        @(posedge hclk); #1;
        test_reset();
        test_idle_handover();
        test_simultaneous();
        test_burst_lock();
        test_wait_states();
        test_error();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
